// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, 34-cycle latency.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 multiplier.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_num,
  output logic            busy,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  state_t              state_q;
  logic [5:0]          cnt_q;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic                neg_q;
  logic                divzero_q;
  logic [4:0]          wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;

  logic                is_div;
  logic                a_neg;
  logic                b_neg;
  logic                res_neg;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   acc_d;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     wb_data_d;

  // Operand signedness and the sign the magnitude result must take in FIX.
  always_comb begin
    is_div  = funct3[2];
    a_neg   = rs1_data[XLEN-1] & (is_div ? ~funct3[0] : (funct3 == OP_MULH || funct3 == OP_MULHSU));
    b_neg   = rs2_data[XLEN-1] & (is_div ? ~funct3[0] : (funct3 == OP_MULH));
    a_mag   = a_neg ? -rs1_data : rs1_data;
    b_mag   = b_neg ? -rs2_data : rs2_data;
    res_neg = (is_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[XLEN];
    if (op_q[2])
      acc_d = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
  end

  // A zero divisor naturally yields remainder |a|, so only the quotient needs forcing.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = divzero_q ? {XLEN{1'b1}} : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:           wb_data_d = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:           wb_data_d = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:   wb_data_d = quot_fix;
      default:          wb_data_d = rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN+1:0] fast_a;
  logic [2*XLEN+1:0] fast_b;
  logic [2*XLEN+1:0] fast_prod;

  always_comb begin
    fast_a    = {{(XLEN+2){a_neg}}, rs1_data};
    fast_b    = {{(XLEN+2){b_neg}}, rs2_data};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 3'd0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      divzero_q <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= funct3;
            wb_rd_q   <= rd_num;
            neg_q     <= res_neg;
            divzero_q <= is_div && (rs2_data == '0);
            cnt_q     <= 6'd0;
            opnd_q    <= is_div ? b_mag : a_mag;
            acc_q     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            state_q   <= CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div) begin
              acc_q   <= fast_prod[2*XLEN-1:0];
              neg_q   <= 1'b0;
              state_q <= FIX;
            end
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31)
            state_q <= FIX;
        end
        FIX: begin
          wb_data_q <= wb_data_d;
          state_q   <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign wb_en   = (state_q == DONE) && !kill;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs, a monitor pops and checks them.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_num = 5'd0;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int cyc = 0;
  int total = 0;
  int bad = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_num   (rd_num),
    .busy     (busy),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one start for a cycle; the expected write-back is queued only if it should be accepted.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expv, input bit accept);
    exp_t e;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_num   = rd;
    start    = 1'b1;
    if (accept) begin
      e.cyc  = cyc + (f[2] ? DIV_LAT : MUL_LAT);
      e.rd   = rd;
      e.data = expv;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("[TB] FAIL wait_idle_timeout actual=busy%0d/pending%0d required=idle", busy, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every wb_en pulse must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (wb_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_wb_en actual=1 required=0 (cycle %0d, data 0x%08h)", cyc, wb_data);
      end else begin
        e = sb.pop_front();
        checkOutput("wb_data", wb_data, e.data);
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        checkOutput("wb_cycle", cyc, e.cyc);
      end
    end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL missing_wb_en actual=none required=cycle%0d", e.cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_wb_en", {31'd0, wb_en}, 32'd0);
    checkOutput("reset_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b1); waitIdle();
    applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 1'b1); waitIdle();
    applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 1'b1); waitIdle();
    applyStimulus(3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 1'b1); waitIdle();
    applyStimulus(3'b001, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 1'b1); waitIdle();
    applyStimulus(3'b011, 32'h80000000, 32'h00000004, 5'd10, 32'h00000002, 1'b1); waitIdle();
    applyStimulus(3'b000, 32'h12345678, 32'h00000010, 5'd0,  32'h23456780, 1'b1); waitIdle();
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFD, 1'b1); waitIdle();
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFF, 1'b1); waitIdle();
    applyStimulus(3'b100, 32'd7,        32'hFFFFFFFE, 5'd26, 32'hFFFFFFFD, 1'b1); waitIdle();
    applyStimulus(3'b110, 32'd7,        32'hFFFFFFFE, 5'd27, 32'h00000001, 1'b1); waitIdle();
    applyStimulus(3'b101, 32'd100,      32'd7,        5'd13, 32'd14,       1'b1); waitIdle();
    applyStimulus(3'b111, 32'd100,      32'd7,        5'd14, 32'd2,        1'b1); waitIdle();
    applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1); waitIdle();
    applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000, 1'b1); waitIdle();
    applyStimulus(3'b101, 32'h1234,     32'd0,        5'd17, 32'hFFFFFFFF, 1'b1); waitIdle();
    applyStimulus(3'b111, 32'h1234,     32'd0,        5'd18, 32'h00001234, 1'b1); waitIdle();
    applyStimulus(3'b100, 32'hFFFFFFF9, 32'd0,        5'd19, 32'hFFFFFFFF, 1'b1); waitIdle();
    applyStimulus(3'b110, 32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFF9, 1'b1); waitIdle();

    $display("[TB] starts while busy and in DONE are dropped");
    c = cyc;
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1);
    waitCycles(4);
    applyStimulus(3'b000, 32'd3, 32'd3, 5'd4, 32'd9, 1'b0);
    waitCycles(28);
    checkOutput("in_done_cycle", cyc, c + 34);
    applyStimulus(3'b011, 32'd5, 32'd5, 5'd2, 32'd0, 1'b0);
    applyStimulus(3'b101, 32'd50, 32'd5, 5'd21, 32'd10, 1'b1);
    waitIdle();

    $display("[TB] kill mid-divide");
    applyStimulus(3'b100, 32'd1000, 32'd3, 5'd22, 32'd0, 1'b0);
    waitCycles(9);
    #1;
    checkOutput("busy_before_kill", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #1;
    checkOutput("busy_after_kill", {31'd0, busy}, 32'd0);
    waitCycles(40);

    $display("[TB] reset mid-CALC");
    applyStimulus(3'b101, 32'd77, 32'd5, 5'd23, 32'd0, 1'b0);
    waitCycles(10);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_wb_en", {31'd0, wb_en}, 32'd0);
    checkOutput("midreset_wb_rd", {27'd0, wb_rd}, 32'd0);
    checkOutput("midreset_wb_data", wb_data, 32'd0);
    rst_n = 1'b1;
    waitCycles(40);

    $display("[TB] kill and start together in IDLE");
    funct3   = 3'b101;
    rs1_data = 32'd9;
    rs2_data = 32'd3;
    rd_num   = 5'd28;
    start    = 1'b1;
    kill     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    #1;
    checkOutput("killstart_busy", {31'd0, busy}, 32'd0);
    waitCycles(40);

    $display("[TB] kill during DONE");
    applyStimulus(3'b111, 32'd100, 32'd7, 5'd24, 32'd0, 1'b0);
    waitCycles(33);
    kill = 1'b1;
    #1;
    checkOutput("done_kill_busy", {31'd0, busy}, 32'd1);
    checkOutput("done_kill_wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    checkOutput("after_done_kill_busy", {31'd0, busy}, 32'd0);
    waitCycles(5);

    applyStimulus(3'b000, 32'd5, 32'd6, 5'd25, 32'd30, 1'b1);
    waitIdle();
    waitCycles(3);

    checkOutput("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
